uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter among N_REQ requesters.
- Each requester offers a W_DATA-bit word bundle over a valid/ready handshake.
- The arbiter captures one winner's bundle into an output register and presents it to the transmitter's s_valid/s_data/s_ready port.
- It enforces a programmable idle gap between successive transfers.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// A winner's bundle is captured into an output register and offered downstream over a
// valid/ready handshake. An optional idle gap follows each downstream handshake.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   req_valid  per-requester valid
//   req_data   per-requester bundle, packed [N_REQ-1:0][W_DATA-1:0]
//   req_mask   per-requester enable (0 = ignored)
//   req_ready  per-requester accept, one-hot or zero, only in IDLE
//   m_valid    to transmitter s_valid
//   m_data     to transmitter s_data
//   m_ready    from transmitter s_ready
//   m_src      index of the requester whose bundle is in m_data
//   busy       high whenever the arbiter is not idle
module uart_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned W_DATA     = 24,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned IdxW      = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][W_DATA-1:0]  req_data,
    input  logic [N_REQ-1:0]              req_mask,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          m_valid,
    output logic [W_DATA-1:0]             m_data,
    input  logic                          m_ready,
    output logic [IdxW-1:0]               m_src,
    output logic                          busy
);

    localparam int unsigned CntW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Last counter value spent in GAP; unused when GAP_CYCLES is 0.
    localparam logic [CntW-1:0] GapLast = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic [IdxW-1:0]   m_src_q, m_src_d;
    logic [W_DATA-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;

    logic [N_REQ-1:0]  eligible;
    logic              found;
    logic [IdxW-1:0]   winner;

    assign eligible = req_valid & req_mask;

    // Rotating priority scan starting just after the last granted requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            logic [IdxW-1:0] cand;
            cand = IdxW'((32'(last_grant_q) + 32'd1 + i) % N_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        // Gated by rstn so nothing is accepted while reset is asserted.
        if (rstn && state_q == StIdle && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        m_src_d      = m_src_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    m_data_d     = req_data[winner];
                    m_src_d      = winner;
                    last_grant_d = winner;
                    m_valid_d    = 1'b1;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            gap_cnt_q    <= '0;
            last_grant_q <= IdxW'(N_REQ - 1);
            m_src_q      <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            m_src_q      <= m_src_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_src   = m_src_q;
    assign busy    = (state_q != StIdle);

endmodule
